// File: rtl/cic_interpolator.sv
// CIC interpolator: comb chain at the input rate, zero-stuffing upsampler and
// integrator chain at the clock rate, output scaled so DC gain is exactly one.
module cic_interpolator #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int RATE   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid
);
  localparam int LG = $clog2(RATE);
  localparam int WI = WIDTH + (STAGES - 1) * LG;

  logic [LG-1:0]                ph;
  logic [STAGES-1:0][WI-1:0]    dly, dly_nxt;
  logic [STAGES-1:0][WI-1:0]    intg, intg_nxt;
  logic [WI-1:0]                acc, u;
  logic                         accept, step;

  assign in_ready = (ph == '0) && !rst;
  assign accept   = in_valid && in_ready;
  assign step     = accept || (ph != '0);

  // Wrapping arithmetic throughout; the integrator growth cancels the comb
  // wrap so the final scaled result is always exact.
  always_comb begin
    acc = WI'(in_data);
    for (int k = 0; k < STAGES; k++) begin
      dly_nxt[k] = acc;
      acc        = acc - dly[k];
    end
    u = accept ? acc : '0;
    intg_nxt[0] = intg[0] + u;
    for (int k = 1; k < STAGES; k++)
      intg_nxt[k] = intg[k] + intg[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph        <= '0;
      dly       <= '0;
      intg      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= step;
      if (accept) dly <= dly_nxt;
      if (step) begin
        ph       <= ph + LG'(1);
        intg     <= intg_nxt;
        // Top WIDTH bits = arithmetic shift right by (STAGES-1)*log2(RATE).
        out_data <= intg_nxt[STAGES-1][WI-1 -: WIDTH];
      end
    end
  end
endmodule
